uart_tx_arbiter: RTL

- Shares one uart_tx transmitter among NUM_REQ independent byte producers, for example a debug console, a status reporter and a log streamer.
- Arbitration is round-robin with burst locking: a granted requester keeps the line until it marks its last beat or hits MAX_BURST beats, so its frames are not interleaved with other sources.
- Sits between the producers and uart_tx. It drives uart_tx i_vld/i_data and takes uart_tx o_rdy.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/rr_picker.sv | 22 ++
 rtl/uart_tx_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit-side blocks.
// Holds the arbiter state type and the round-robin pick function.
package uart_pkg;

  localparam int UART_DEFAULT_DATA_WIDTH = 8;
  localparam int RR_MAX_REQ = 8;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  // First set bit of req at or above ptr, wrapping modulo n.
  function automatic logic [2:0] rr_pick(
    input logic [7:0] req,
    input logic [2:0] ptr,
    input int         n
  );
    logic [2:0] idx;
    logic       hit;
    int         j;
    idx = '0;
    hit = 1'b0;
    for (int i = 0; i < RR_MAX_REQ; i++) begin
      if (i < n && !hit) begin
        j = (int'(ptr) + i) % n;
        if (req[j[2:0]]) begin
          idx = j[2:0];
          hit = 1'b1;
        end
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker over up to eight requesters.
// Shared between the tx arbiter and the rx dispatcher.
module rr_picker
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);

  localparam int SW = $clog2(NUM_REQ);

  // Search upward from ptr with wrap-around.
  always_comb begin
    any = |req;
    idx = SW'(rr_pick(8'(req), 3'(ptr), NUM_REQ));
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, burst-locked arbiter feeding a single uart_tx.
// One output register sits between the producers and the transmitter.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = UART_DEFAULT_DATA_WIDTH,
  parameter int MAX_BURST  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_vld,
  input  logic [NUM_REQ-1:0]              req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_rdy,
  output logic                            o_vld,
  output logic [DATA_WIDTH-1:0]           o_data,
  output logic [$clog2(NUM_REQ)-1:0]      o_src,
  input  logic                            i_rdy,
  output logic                            o_busy
);

  localparam int SW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 ||
      MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_param
    $fatal(1, "uart_tx_arbiter: illegal NUM_REQ or MAX_BURST");
  end

  arb_state_t    state, state_n;
  logic [SW-1:0] grant, grant_n;
  logic [SW-1:0] ptr, ptr_n;
  logic [SW-1:0] pick_idx;
  logic          pick_any;
  logic [CW-1:0] beat_cnt, cnt_n, cnt_inc;
  logic          room;
  logic          accept;
  logic          rel;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req (req_vld),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Handshake qualifiers: register can take a beat if empty or draining.
  always_comb begin
    room    = (state == GRANT) && (!o_vld || i_rdy);
    req_rdy = '0;
    if (room) req_rdy[grant] = 1'b1;
    accept  = room && req_vld[grant];
    cnt_inc = beat_cnt + 1'b1;
    rel     = accept &&
              (req_last[grant] || cnt_inc == CW'(MAX_BURST));
  end

  // Next-state, grant, pointer and beat counter.
  always_comb begin
    state_n = state;
    grant_n = grant;
    ptr_n   = ptr;
    cnt_n   = beat_cnt;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          state_n = GRANT;
          grant_n = pick_idx;
          cnt_n   = '0;
        end
      end
      GRANT: begin
        if (accept) cnt_n = cnt_inc;
        if (rel) begin
          state_n = IDLE;
          ptr_n   = (grant == SW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      ptr      <= ptr_n;
      beat_cnt <= cnt_n;
    end
  end

  // Output register: load on accept, empty on a lone downstream transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_vld  <= 1'b0;
      o_data <= '0;
      o_src  <= '0;
    end else if (accept) begin
      o_vld  <= 1'b1;
      o_data <= req_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
      o_src  <= grant;
    end else if (o_vld && i_rdy) begin
      o_vld  <= 1'b0;
    end
  end

  // Busy while a grant is open or a character is waiting.
  always_comb o_busy = (state == GRANT) || o_vld;

endmodule
